// File: rtl/alu_cmd_issuer.sv
// Command FIFO and issue pipeline feeding the registered ALU wrapper; op is delayed one cycle.
// Optional per-command tags: define ALU_ISSUER_TAG_EN to add cmd_tag/res_tag.
package alu_pkg;
  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_AND = 2'd2,
    OP_XOR = 2'd3
  } op_t;
endpackage

module alu_cmd_issuer
  import alu_pkg::*;
#(
  parameter int N     = 4,
  parameter int DEPTH = 4,
  parameter int TAGW  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [N-1:0]             cmd_a,
  input  logic [N-1:0]             cmd_b,
  input  op_t                      cmd_op,
  input  logic                     issue_en,
  output logic [N-1:0]             A_in,
  output logic [N-1:0]             B_in,
  output op_t                      op,
  output logic                     res_valid,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     busy
`ifdef ALU_ISSUER_TAG_EN
  ,
  input  logic [TAGW-1:0]          cmd_tag,
  output logic [TAGW-1:0]          res_tag
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TAGW < 1 || N < 1) begin : g_param_check
    $error("alu_cmd_issuer: DEPTH must be a power of two >= 2, TAGW and N >= 1");
  end

  logic [N-1:0]  r_mem_a  [DEPTH];
  logic [N-1:0]  r_mem_b  [DEPTH];
  op_t           r_mem_op [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count;

  logic [N-1:0]  r_a_in, r_b_in;
  op_t           r_op_q, r_op;
  logic          r_v0, r_v1, r_v2;

  logic w_full, w_empty, w_push, w_pop;

  assign w_full    = (r_count == FULL_CNT);
  assign w_empty   = (r_count == '0);
  assign w_push    = cmd_valid && !w_full;
  assign w_pop     = issue_en && !w_empty;

  assign cmd_ready  = !w_full;
  assign fifo_count = r_count;
  assign A_in       = r_a_in;
  assign B_in       = r_b_in;
  assign op         = r_op;
  assign res_valid  = r_v2;
  assign busy       = !w_empty || r_v0 || r_v1 || r_v2;

  // NOTE: storage has no reset; pointers and count decide which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_a[r_wr_ptr]  <= cmd_a;
      r_mem_b[r_wr_ptr]  <= cmd_b;
      r_mem_op[r_wr_ptr] <= cmd_op;
    end
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // op trails A/B by one edge because the wrapper registers operands but not op.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_in <= '0;
      r_b_in <= '0;
      r_op_q <= op_t'(0);
      r_op   <= op_t'(0);
      r_v0   <= 1'b0;
      r_v1   <= 1'b0;
      r_v2   <= 1'b0;
    end else begin
      r_v0 <= w_pop;
      if (w_pop) begin
        r_a_in <= r_mem_a[r_rd_ptr];
        r_b_in <= r_mem_b[r_rd_ptr];
        r_op_q <= r_mem_op[r_rd_ptr];
      end
      r_v1 <= r_v0;
      if (r_v0) r_op <= r_op_q;
      r_v2 <= r_v1;
    end
  end

`ifdef ALU_ISSUER_TAG_EN
  logic [TAGW-1:0] r_mem_tag [DEPTH];
  logic [TAGW-1:0] r_tag_q, r_tag1, r_tag2;

  always_ff @(posedge clk) begin
    if (w_push) r_mem_tag[r_wr_ptr] <= cmd_tag;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tag_q <= '0;
      r_tag1  <= '0;
      r_tag2  <= '0;
    end else begin
      if (w_pop) r_tag_q <= r_mem_tag[r_rd_ptr];
      if (r_v0)  r_tag1  <= r_tag_q;
      if (r_v1)  r_tag2  <= r_tag1;
    end
  end

  assign res_tag = r_tag2;
`endif

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Scoreboard bench for alu_cmd_issuer with a behavioural model of the downstream registered ALU wrapper.
// Tag checks are compiled in when ALU_ISSUER_TAG_EN is defined.
module tb_alu_cmd_issuer;
  import alu_pkg::*;

  typedef struct {
    logic [3:0] y;
    logic [1:0] tag;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_a, cmd_b;
  op_t        cmd_op;
  logic       issue_en;
  logic [3:0] A_in, B_in;
  op_t        op;
  logic       res_valid;
  logic [2:0] fifo_count;
  logic       busy;
`ifdef ALU_ISSUER_TAG_EN
  logic [1:0] cmd_tag;
  logic [1:0] res_tag;
`endif

  alu_cmd_issuer #(.N(4), .DEPTH(4), .TAGW(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_op     (cmd_op),
    .issue_en   (issue_en),
    .A_in       (A_in),
    .B_in       (B_in),
    .op         (op),
    .res_valid  (res_valid),
    .fifo_count (fifo_count),
    .busy       (busy)
`ifdef ALU_ISSUER_TAG_EN
    ,
    .cmd_tag    (cmd_tag),
    .res_tag    (res_tag)
`endif
  );

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  exp_t sb[$];
  int   rv_cycles[$];

  logic [3:0] w_ra, w_rb, w_y;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [3:0] alu_f(input logic [3:0] a, input logic [3:0] b, input op_t o);
    case (o)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      default: return a ^ b;
    endcase
  endfunction

  // Downstream wrapper: A/B registered, op combinational, Y_out registered.
  always @(posedge clk) begin
    if (rst) begin
      w_ra <= '0;
      w_rb <= '0;
      w_y  <= '0;
    end else begin
      w_ra <= A_in;
      w_rb <= B_in;
      w_y  <= alu_f(w_ra, w_rb, op);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && res_valid) begin
      rv_cycles.push_back(cyc);
      if (sb.size() == 0) begin
        check("spurious_res_valid", 32'(res_valid), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("y_out", 32'(w_y), 32'(e.y));
`ifdef ALU_ISSUER_TAG_EN
        check("res_tag", 32'(res_tag), 32'(e.tag));
`endif
      end
    end
  end

  task automatic push(input logic [3:0] a, input logic [3:0] b, input op_t o,
                      input logic [1:0] tag, input logic [3:0] y, input bit track);
    int guard = 0;
    exp_t e;
    cmd_valid = 1'b1;
    cmd_a     = a;
    cmd_b     = b;
    cmd_op    = o;
`ifdef ALU_ISSUER_TAG_EN
    cmd_tag   = tag;
`endif
    while (!cmd_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    check("push_accept_timeout", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    e.y   = y;
    e.tag = tag;
    if (track) sb.push_back(e);
  endtask

  task automatic drain(input string name);
    int guard = 0;
    while ((sb.size() != 0 || busy) && guard < 40) begin
      @(posedge clk); #1;
      guard++;
    end
    check({name, "_drained"}, 32'(sb.size()), 32'd0);
    check({name, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e5;
    int   p1c;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_a     = '0;
    cmd_b     = '0;
    cmd_op    = OP_ADD;
    issue_en  = 1'b0;
`ifdef ALU_ISSUER_TAG_EN
    cmd_tag   = '0;
`endif
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_a_in", 32'(A_in), 32'd0);
    check("rst_b_in", 32'(B_in), 32'd0);
    check("rst_op", 32'(op), 32'd0);

    // 1: single command, latency
    issue_en = 1'b1;
    push(4'd3, 4'd5, OP_ADD, 2'd0, 4'd8, 1'b1);
    check("t1_count_after_push", 32'(fifo_count), 32'd1);
    @(posedge clk); #1;
    check("t1_a_in", 32'(A_in), 32'd3);
    check("t1_b_in", 32'(B_in), 32'd5);
    check("t1_count_after_pop", 32'(fifo_count), 32'd0);
    @(posedge clk); #1;
    check("t1_op", 32'(op), 32'(OP_ADD));
    check("t1_rv_early", 32'(res_valid), 32'd0);
    @(posedge clk); #1;
    check("t1_rv_on_time", 32'(res_valid), 32'd1);
    @(posedge clk); #1;
    check("t1_rv_one_cycle", 32'(res_valid), 32'd0);
    drain("t1");

    // 2: back-to-back burst, contiguous results, wrap at N=4
    rv_cycles.delete();
    push(4'd1,  4'd1, OP_ADD, 2'd0, 4'd2, 1'b1);
    push(4'd2,  4'd2, OP_ADD, 2'd0, 4'd4, 1'b1);
    push(4'd7,  4'd1, OP_ADD, 2'd0, 4'd8, 1'b1);
    push(4'd15, 4'd1, OP_ADD, 2'd0, 4'd0, 1'b1);
    drain("t2");
    check("t2_rv_count", 32'(rv_cycles.size()), 32'd4);
    for (int i = 1; i < 4 && i < rv_cycles.size(); i++)
      check("t2_rv_contiguous", 32'(rv_cycles[i] - rv_cycles[i-1]), 32'd1);

    // 3: backpressure with issue held off
    issue_en = 1'b0;
    push(4'd9,  4'd4,  OP_SUB, 2'd0, 4'd5,  1'b1);
    push(4'd12, 4'd10, OP_AND, 2'd0, 4'd8,  1'b1);
    push(4'd6,  4'd3,  OP_XOR, 2'd0, 4'd5,  1'b1);
    push(4'd2,  4'd5,  OP_SUB, 2'd0, 4'd13, 1'b1);
    check("t3_full_count", 32'(fifo_count), 32'd4);
    check("t3_ready_low", 32'(cmd_ready), 32'd0);
    cmd_valid = 1'b1;
    cmd_a     = 4'd15;
    cmd_b     = 4'd15;
    cmd_op    = OP_ADD;
    repeat (3) begin @(posedge clk); #1; end
    check("t3_5th_blocked", 32'(fifo_count), 32'd4);
    issue_en = 1'b1;
    @(posedge clk); #1;
    check("t3_ready_after_pop", 32'(cmd_ready), 32'd1);
    check("t3_count_after_pop", 32'(fifo_count), 32'd3);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    e5.y   = 4'd14;
    e5.tag = 2'd0;
    sb.push_back(e5);
    check("t3_count_push_pop", 32'(fifo_count), 32'd3);
    drain("t3");

    // 4: stall issue for two cycles after the second pop
    issue_en = 1'b0;
    rv_cycles.delete();
    push(4'd1,  4'd2, OP_ADD, 2'd0, 4'd3,  1'b1);
    push(4'd3,  4'd4, OP_ADD, 2'd0, 4'd7,  1'b1);
    push(4'd8,  4'd8, OP_SUB, 2'd0, 4'd0,  1'b1);
    push(4'd10, 4'd5, OP_XOR, 2'd0, 4'd15, 1'b1);
    issue_en = 1'b1;
    @(posedge clk); #1;
    p1c = cyc;
    @(posedge clk); #1;
    issue_en = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    issue_en = 1'b1;
    drain("t4");
    check("t4_rv_count", 32'(rv_cycles.size()), 32'd4);
    if (rv_cycles.size() == 4) begin
      check("t4_rv0_cycle", 32'(rv_cycles[0]), 32'(p1c + 2));
      check("t4_rv1_cycle", 32'(rv_cycles[1]), 32'(p1c + 3));
      check("t4_rv2_cycle", 32'(rv_cycles[2]), 32'(p1c + 6));
      check("t4_rv3_cycle", 32'(rv_cycles[3]), 32'(p1c + 7));
    end

    // 5: reset one cycle after a pop discards everything
    issue_en = 1'b0;
    rv_cycles.delete();
    push(4'd7, 4'd7, OP_ADD, 2'd0, 4'd14, 1'b0);
    push(4'd1, 4'd1, OP_SUB, 2'd0, 4'd0,  1'b0);
    issue_en = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("t5_count", 32'(fifo_count), 32'd0);
    check("t5_a_in", 32'(A_in), 32'd0);
    check("t5_b_in", 32'(B_in), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_ready", 32'(cmd_ready), 32'd1);
    repeat (6) begin @(posedge clk); #1; end
    check("t5_no_results", 32'(rv_cycles.size()), 32'd0);

`ifdef ALU_ISSUER_TAG_EN
    // 6: tags travel with their commands
    push(4'd1, 4'd0, OP_ADD, 2'd0, 4'd1, 1'b1);
    push(4'd2, 4'd0, OP_ADD, 2'd1, 4'd2, 1'b1);
    push(4'd3, 4'd0, OP_ADD, 2'd2, 4'd3, 1'b1);
    push(4'd4, 4'd0, OP_ADD, 2'd3, 4'd4, 1'b1);
    drain("t6");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_cmd_issuer.md
Name: alu_cmd_issuer

Overview:
- Upstream command stage for the registered ALU wrapper.
- Accepts operand/opcode commands over a valid/ready handshake and buffers them in a small FIFO.
- Issues one command per cycle onto the wrapper's A_in/B_in/op inputs. The wrapper registers A/B but not op, so op is delayed one cycle to stay aligned.
- Tracks in-flight commands and flags the exact cycle the wrapper's Y_out holds each result.

Parameters:
- N, 4, operand width; must match the downstream wrapper.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- TAGW, 2, tag width; used only with ALU_ISSUER_TAG_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset. Shared with the downstream wrapper.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO can accept; equals !full.
- cmd_a  in  N  operand A.
- cmd_b  in  N  operand B.
- cmd_op  in  op_t  opcode (alu_pkg).
- issue_en  in  1  1 = issue allowed; 0 = hold head in FIFO.
- A_in  out  N  to wrapper A_in; registered.
- B_in  out  N  to wrapper B_in; registered.
- op  out  op_t  to wrapper op; registered, one cycle behind A_in/B_in.
- res_valid  out  1  high in a cycle where wrapper Y_out holds an issued command's result.
- fifo_count  out  $clog2(DEPTH)+1  entries stored.
- busy  out  1  FIFO non-empty or any command in flight.

Behaviour:
Reset (synchronous, sampled on clk edge with rst=1):
- FIFO empties; fifo_count=0.
- A_in=0, B_in=0, op=op_t'(0).
- In-flight valid pipeline cleared; res_valid=0, busy=0.
- cmd_ready=1 in the first cycle after reset release.

Handshake:
- Push on edge where cmd_valid && cmd_ready.
- cmd_ready is never combinationally dependent on pop: when full, cmd_ready=0 even if a pop happens the same cycle.
- cmd_a/cmd_b/cmd_op are ignored when not pushed.

Issue:
- Pop on edge where issue_en && !empty.
- On the pop edge E0: A_in<=head.a, B_in<=head.b, op_q<=head.op, v0<=1. Otherwise A_in/B_in hold their value and v0<=0.
- Edge E1 (the wrapper captures A/B): op<=op_q, v1<=v0. op holds its value when v0=0.
- Edge E2 (the wrapper registers Y_out): v2<=v1.
- res_valid=v2, so it is high during the cycle after E2, aligned with Y_out.

Latency and throughput:
- Into empty FIFO: accept edge a; issue edge a+1; res_valid high in the cycle after edge a+3.
- Throughput is 1 command per cycle; back-to-back pops produce contiguous res_valid.

FIFO and counter:
- Circular buffer; read/write pointers wrap at DEPTH.
- Push and pop on the same edge: count unchanged, both pointers advance.
- Pop on empty and push on full cannot occur, by construction.

Other rules:
- issue_en=0 stops popping only; commands already in flight (v0..v2) complete normally.
- busy = !empty | v0 | v1 | v2.
- rst mid-operation: all in-flight results are discarded, so res_valid stays 0 for them; commands sitting in the FIFO are lost.
- op must never change in a cycle where v1's command is being evaluated; guaranteed by the op register updating only at E1.

Optional Feature:
ALU_ISSUER_TAG_EN
- Defined:
  - Adds port cmd_tag (in, TAGW), stored per FIFO entry.
  - Adds port res_tag (out, TAGW), piped alongside v0..v2 and valid when res_valid=1.
  - res_tag resets to 0.
- Undefined: no tag ports and no tag storage; all other behaviour is identical.

Test Plan:
1. Single command: reset, then push a=3, b=5, op=ADD with issue_en=1 → A_in=3, B_in=5 after edge a+1; op=ADD after a+2; res_valid=1 for exactly one cycle after a+3 with Y_out=8.
2. Burst of 4 back-to-back (1+1, 2+2, 7+1, 15+1) → res_valid high for 4 consecutive cycles with Y_out = 2, 4, 8, 0 (wrap, N=4).
3. Backpressure: issue_en=0, push 5 commands → cmd_ready drops after the 4th; fifo_count=4; the 5th is not accepted until issue_en=1, then pops in order.
4. Stall mid-burst: drop issue_en for 2 cycles after the 2nd pop → the first two results still arrive on schedule; res_valid has a 2-cycle gap; order is preserved.
5. Reset mid-flight: assert rst the cycle after a pop → res_valid never rises for that command; fifo_count=0; A_in=B_in=0; busy=0.
6. With ALU_ISSUER_TAG_EN: push tags 0, 1, 2, 3 in a burst → res_tag = 0, 1, 2, 3 on the corresponding res_valid cycles.
